// File: rtl/bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI bridge: FSM encodings, AXI IDs
// and fixed burst/size helpers.
package bridge_pkg;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  // SRAM size code (bytes = 1 << size) maps directly onto AXI size.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/bridge_wr_ctrl.sv
// Write path of the bridge: W FSM driving AW/W and consuming B.
// With BRIDGE_POSTED_WRITE_EN defined, the CPU is acknowledged once AW and W complete.
module bridge_wr_ctrl
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        accept,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [1:0]  req_size,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        w_idle,
  output logic        wr_data_ok,
  output logic [1:0]  w_state_dbg
);

  w_state_t w_state;
  logic     aw_done;
  logic     w_done;
  logic     send_done;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done     = !awvalid || awready;
  assign w_done      = !wvalid || wready;
  assign send_done   = (w_state == W_SEND) && aw_done && w_done;
  assign w_idle      = (w_state == W_IDLE);
  assign w_state_dbg = w_state;

`ifdef BRIDGE_POSTED_WRITE_EN
  assign wr_data_ok = send_done;
`else
  assign wr_data_ok = (w_state == W_RESP) && bvalid;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (accept) begin
            awaddr  <= req_addr;
            awsize  <= axi_size(req_size);
            wdata   <= req_wdata;
            wstrb   <= req_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            w_state <= W_SEND;
          end
        end
        W_SEND: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (send_done)          w_state <= W_RESP;
        end
        W_RESP: begin
          if (bvalid) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's SRAM-like inst/data ports onto one AXI master; AR arbitration
// and R routing live here, writes in bridge_wr_ctrl. Option: BRIDGE_POSTED_WRITE_EN.
module sram_axi_bridge
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        ar_state_dbg,
  output logic [1:0]  w_state_dbg
);

  // Handshakes: an SRAM request is taken when req & addr_ok at a rising edge;
  // data_ok is a one-cycle response pulse. AXI channels transfer on valid & ready,
  // and a raised valid keeps its payload stable until that handshake.

  ar_state_t ar_state;
  logic      inst_rd_pend;
  logic      data_rd_pend;
  logic      w_idle;
  logic      wr_data_ok;
  logic      data_rd_ok;
  logic      data_rd_take;
  logic      data_wr_ok;
  logic      data_wr_take;
  logic      inst_take;
  logic      inst_rd_resp;
  logic      data_rd_resp;
  logic      unused_ok;

  assign arlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = ID_DATA;
  assign awlen   = LEN_SINGLE;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;

  // Data reads wait for the write path to be idle; data wins AR over inst.
  assign data_rd_ok        = (ar_state == AR_IDLE) && w_idle && !data_rd_pend;
  assign data_rd_take      = data_sram_req && !data_sram_wr && data_rd_ok;
  assign data_wr_ok        = w_idle && !data_rd_pend;
  assign data_wr_take      = data_sram_req && data_sram_wr && data_wr_ok;
  assign data_sram_addr_ok = data_sram_wr ? data_wr_ok : data_rd_ok;
  assign inst_sram_addr_ok = (ar_state == AR_IDLE) && !inst_rd_pend && !data_rd_take;
  assign inst_take         = inst_sram_req && inst_sram_addr_ok;

  // Responses with no matching outstanding read (e.g. issued before reset) are dropped.
  assign inst_rd_resp      = rvalid && (rid == ID_INST) && inst_rd_pend;
  assign data_rd_resp      = rvalid && (rid == ID_DATA) && data_rd_pend;
  assign inst_sram_data_ok = inst_rd_resp;
  assign data_sram_data_ok = data_rd_resp || wr_data_ok;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;
  assign ar_state_dbg      = ar_state;

  // The inst port is read-only and AXI error/last/id fields carry no meaning here.
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_state     <= AR_IDLE;
      arvalid      <= 1'b0;
      arid         <= '0;
      araddr       <= '0;
      arsize       <= '0;
      inst_rd_pend <= 1'b0;
      data_rd_pend <= 1'b0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (data_rd_take) begin
            arid     <= ID_DATA;
            araddr   <= data_sram_addr;
            arsize   <= axi_size(data_sram_size);
            arvalid  <= 1'b1;
            ar_state <= AR_SEND;
          end else if (inst_take) begin
            arid     <= ID_INST;
            araddr   <= inst_sram_addr;
            arsize   <= axi_size(inst_sram_size);
            arvalid  <= 1'b1;
            ar_state <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (arready) begin
            arvalid  <= 1'b0;
            ar_state <= AR_IDLE;
          end
        end
        default: ar_state <= AR_IDLE;
      endcase

      if (data_rd_take)      data_rd_pend <= 1'b1;
      else if (data_rd_resp) data_rd_pend <= 1'b0;
      if (inst_take)         inst_rd_pend <= 1'b1;
      else if (inst_rd_resp) inst_rd_pend <= 1'b0;
    end
  end

  bridge_wr_ctrl u_wr_ctrl (
    .clk         (clk),
    .resetn      (resetn),
    .accept      (data_wr_take),
    .req_addr    (data_sram_addr),
    .req_wdata   (data_sram_wdata),
    .req_wstrb   (data_sram_wstrb),
    .req_size    (data_sram_size),
    .awaddr      (awaddr),
    .awsize      (awsize),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bvalid      (bvalid),
    .w_idle      (w_idle),
    .wr_data_ok  (wr_data_ok),
    .w_state_dbg (w_state_dbg)
  );

endmodule
